// File: rtl/adc_frontend_pkg.sv
// Shared constants and helpers for the receive-side ADC front end:
// register addresses, sample widths and the saturation/magnitude helpers.
package adc_frontend_pkg;

    localparam int ADC_W      = 12;
    localparam int SMP_W      = 16;
    localparam int INTEG_W    = 32;
    localparam int NUM_CH     = 4;
    localparam int RSSI_SHIFT = 10;
    localparam int ACC_W      = SMP_W + RSSI_SHIFT;

    localparam logic [6:0] FR_RX_MUX    = 7'd8;
    localparam logic [6:0] FR_ADC_OFS_0 = 7'd10;
    localparam logic [6:0] FR_DCO_EN    = 7'd46;

    // Clamp a 17-bit signed difference into the 16-bit sample range.
    function automatic logic signed [SMP_W-1:0] sat16(input logic signed [SMP_W:0] v);
        logic signed [SMP_W-1:0] r;
        if (v[SMP_W] != v[SMP_W-1]) begin
            r = v[SMP_W] ? 16'sh8000 : 16'sh7FFF;
        end else begin
            r = v[SMP_W-1:0];
        end
        return r;
    endfunction

    // Magnitude of a 16-bit sample; -32768 clamps to 32767 so it fits 15 bits.
    function automatic logic [SMP_W-2:0] abs_sat(input logic signed [SMP_W-1:0] v);
        logic signed [SMP_W-1:0] n;
        logic [SMP_W-2:0]        r;
        n = -v;
        if (!v[SMP_W-1]) begin
            r = v[SMP_W-2:0];
        end else if (v == 16'sh8000) begin
            r = 15'h7FFF;
        end else begin
            r = n[SMP_W-2:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/adc_frontend_dc_corrector.sv
// Per-channel DC-offset removal: a closed-loop integrator tracks the mean of
// the incoming sample and its upper half is subtracted from the input.
// Named adc_dc_corrector; instantiated once per ADC channel.
module adc_dc_corrector
    import adc_frontend_pkg::*;
(
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    upd_en_i,
    input  logic                    ofs_wr_i,
    input  logic [SMP_W-1:0]        ofs_data_i,
    input  logic signed [SMP_W-1:0] adc_i,
    output logic signed [SMP_W-1:0] corr_o
);

    logic signed [INTEG_W-1:0] integ_q, integ_d;
    logic signed [SMP_W-1:0]   corr_q, corr_d;
    logic signed [SMP_W:0]     diff;

    // Subtract the tracked offset and pick the next integrator value;
    // an offset preload takes priority over the loop update.
    always_comb begin
        diff    = {adc_i[SMP_W-1], adc_i} - {integ_q[INTEG_W-1], integ_q[INTEG_W-1 -: SMP_W]};
        corr_d  = sat16(diff);
        integ_d = integ_q;
        if (ofs_wr_i) begin
            integ_d = {ofs_data_i, 16'h0000};
        end else if (upd_en_i) begin
            integ_d = integ_q + {{(INTEG_W-SMP_W){corr_q[SMP_W-1]}}, corr_q};
        end
    end

    // Stage-2 register: corrected sample and integrator state.
    always_ff @(posedge clock) begin
        if (reset) begin
            integ_q <= '0;
            corr_q  <= '0;
        end else begin
            integ_q <= integ_d;
            corr_q  <= corr_d;
        end
    end

    assign corr_o = corr_q;

endmodule

// File: rtl/adc_frontend.sv
// Receive ADC front end: registers and widens four 12-bit ADC inputs,
// removes DC offset per channel, measures level/overrange (RSSI) and routes
// the corrected samples to the I/Q inputs of four DDCs.
module adc_frontend
    import adc_frontend_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              serial_strobe,
    input  logic [6:0]        serial_addr,
    input  logic [31:0]       serial_data,
    input  logic [ADC_W-1:0]  rx_a_a,
    input  logic [ADC_W-1:0]  rx_b_a,
    input  logic [ADC_W-1:0]  rx_a_b,
    input  logic [ADC_W-1:0]  rx_b_b,
    output logic [31:0]       rssi_0,
    output logic [31:0]       rssi_1,
    output logic [31:0]       rssi_2,
    output logic [31:0]       rssi_3,
    output logic [SMP_W-1:0]  ddc0_in_i,
    output logic [SMP_W-1:0]  ddc0_in_q,
    output logic [SMP_W-1:0]  ddc1_in_i,
    output logic [SMP_W-1:0]  ddc1_in_q,
    output logic [SMP_W-1:0]  ddc2_in_i,
    output logic [SMP_W-1:0]  ddc2_in_q,
    output logic [SMP_W-1:0]  ddc3_in_i,
    output logic [SMP_W-1:0]  ddc3_in_q,
    output logic [3:0]        rx_numchan
);

    logic [ADC_W-1:0]        rx      [NUM_CH];
    logic signed [SMP_W-1:0] adc_q   [NUM_CH];
    logic signed [SMP_W-1:0] corr    [NUM_CH];
    logic [NUM_CH-1:0]       ofs_wr;
    logic [NUM_CH-1:0]       upd_en;

    logic [31:0]             mux_q;
    logic [NUM_CH-1:0]       dco_en_q;

    logic [ACC_W-1:0]        acc_q   [NUM_CH];
    logic [ACC_W-1:0]        acc_d   [NUM_CH];
    logic [SMP_W-1:0]        level_q [NUM_CH];
    logic [15:0]             over_q  [NUM_CH];
    logic [15:0]             over_d  [NUM_CH];
    logic [SMP_W-2:0]        mag     [NUM_CH];
    logic                    over    [NUM_CH];

    logic [SMP_W-1:0]        ddc_i   [NUM_CH];
    logic [SMP_W-1:0]        ddc_q   [NUM_CH];

    logic                    unused_mux_bits;

    assign rx[0] = rx_a_a;
    assign rx[1] = rx_b_a;
    assign rx[2] = rx_a_b;
    assign rx[3] = rx_b_b;

    // Control registers written over the serial bus.
    always_ff @(posedge clock) begin
        if (reset) begin
            mux_q    <= '0;
            dco_en_q <= '0;
        end else if (serial_strobe) begin
            if (serial_addr == FR_RX_MUX) begin
                mux_q <= serial_data;
            end
            if (serial_addr == FR_DCO_EN) begin
                dco_en_q <= serial_data[NUM_CH-1:0];
            end
        end
    end

    // Per-channel offset-preload strobes and integrator update enables.
    always_comb begin
        for (int n = 0; n < NUM_CH; n++) begin
            ofs_wr[n] = serial_strobe && (serial_addr == 7'(FR_ADC_OFS_0 + 7'(n)));
            upd_en[n] = enable && dco_en_q[n];
        end
    end

    // Stage 1: register the pins and sign-extend to 16 bits (sample in bits [14:3]).
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int n = 0; n < NUM_CH; n++) begin
                adc_q[n] <= '0;
            end
        end else begin
            for (int n = 0; n < NUM_CH; n++) begin
                adc_q[n] <= {rx[n][ADC_W-1], rx[n], 3'b000};
            end
        end
    end

    // Stage 2: DC correction, one corrector per channel.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_dco
        adc_dc_corrector u_dco (
            .clock      (clock),
            .reset      (reset),
            .upd_en_i   (upd_en[g]),
            .ofs_wr_i   (ofs_wr[g]),
            .ofs_data_i (serial_data[SMP_W-1:0]),
            .adc_i      (adc_q[g]),
            .corr_o     (corr[g])
        );
    end

    // RSSI next state: leaky level averager and saturating overrange counter.
    // The raw 12-bit code is recovered from bits [14:3] of the widened sample.
    always_comb begin
        for (int n = 0; n < NUM_CH; n++) begin
            mag[n]    = abs_sat(adc_q[n]);
            acc_d[n]  = acc_q[n] + ACC_W'(mag[n]) - (acc_q[n] >> RSSI_SHIFT);
            over[n]   = (adc_q[n][14:3] == 12'h7FF) || (adc_q[n][14:3] == 12'h800);
            over_d[n] = over_q[n];
            if (over[n] && (over_q[n] != 16'hFFFF)) begin
                over_d[n] = over_q[n] + 16'd1;
            end else if (!over[n] && (over_q[n] != 16'h0000)) begin
                over_d[n] = over_q[n] - 16'd1;
            end
        end
    end

    // RSSI state: averager and counter advance only while enabled; level tracks the accumulator.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int n = 0; n < NUM_CH; n++) begin
                acc_q[n]   <= '0;
                over_q[n]  <= '0;
                level_q[n] <= '0;
            end
        end else begin
            for (int n = 0; n < NUM_CH; n++) begin
                if (enable) begin
                    acc_q[n]  <= acc_d[n];
                    over_q[n] <= over_d[n];
                end
                level_q[n] <= acc_q[n][ACC_W-1 -: SMP_W];
            end
        end
    end

    // DDC routing: 2-bit channel selects per I/Q, with a per-DDC real-mode Q blank.
    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            ddc_i[k] = corr[mux_q[4+4*k +: 2]];
            ddc_q[k] = mux_q[20+k] ? '0 : corr[mux_q[6+4*k +: 2]];
        end
    end

    assign unused_mux_bits = ^mux_q[31:24];

    assign rx_numchan = mux_q[3:0];
    assign rssi_0     = {over_q[0], level_q[0]};
    assign rssi_1     = {over_q[1], level_q[1]};
    assign rssi_2     = {over_q[2], level_q[2]};
    assign rssi_3     = {over_q[3], level_q[3]};
    assign ddc0_in_i  = ddc_i[0];
    assign ddc0_in_q  = ddc_q[0];
    assign ddc1_in_i  = ddc_i[1];
    assign ddc1_in_q  = ddc_q[1];
    assign ddc2_in_i  = ddc_i[2];
    assign ddc2_in_q  = ddc_q[2];
    assign ddc3_in_i  = ddc_i[3];
    assign ddc3_in_q  = ddc_q[3];

endmodule

// File: tb/tb_adc_frontend.sv
// Directed bench for adc_frontend: reset, widening/latency, offset preload,
// DDC routing, DC-loop convergence, saturation and RSSI counting.
module tb_adc_frontend;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic        serial_strobe;
    logic [6:0]  serial_addr;
    logic [31:0] serial_data;
    logic [11:0] rx_a_a, rx_b_a, rx_a_b, rx_b_b;
    logic [31:0] rssi_0, rssi_1, rssi_2, rssi_3;
    logic [15:0] ddc0_in_i, ddc0_in_q, ddc1_in_i, ddc1_in_q;
    logic [15:0] ddc2_in_i, ddc2_in_q, ddc3_in_i, ddc3_in_q;
    logic [3:0]  rx_numchan;

    int checks   = 0;
    int failures = 0;

    adc_frontend dut (
        .clock         (clock),
        .reset         (reset),
        .enable        (enable),
        .serial_strobe (serial_strobe),
        .serial_addr   (serial_addr),
        .serial_data   (serial_data),
        .rx_a_a        (rx_a_a),
        .rx_b_a        (rx_b_a),
        .rx_a_b        (rx_a_b),
        .rx_b_b        (rx_b_b),
        .rssi_0        (rssi_0),
        .rssi_1        (rssi_1),
        .rssi_2        (rssi_2),
        .rssi_3        (rssi_3),
        .ddc0_in_i     (ddc0_in_i),
        .ddc0_in_q     (ddc0_in_q),
        .ddc1_in_i     (ddc1_in_i),
        .ddc1_in_q     (ddc1_in_q),
        .ddc2_in_i     (ddc2_in_i),
        .ddc2_in_q     (ddc2_in_q),
        .ddc3_in_i     (ddc3_in_i),
        .ddc3_in_q     (ddc3_in_q),
        .rx_numchan    (rx_numchan)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance n clocks; inputs are driven and outputs sampled 1 unit after the edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic wr(input logic [6:0] a, input logic [31:0] d);
        serial_strobe = 1'b1;
        serial_addr   = a;
        serial_data   = d;
        step(1);
        serial_strobe = 1'b0;
        serial_addr   = '0;
        serial_data   = '0;
    endtask

    initial begin
        logic signed [15:0] c;
        int  cyc;
        bit  done;

        reset = 1'b1; enable = 1'b0;
        serial_strobe = 1'b0; serial_addr = '0; serial_data = '0;
        rx_a_a = '0; rx_b_a = '0; rx_a_b = '0; rx_b_b = '0;
        step(3);
        reset = 1'b0;
        chk("rst_ddc0_i", 32'(ddc0_in_i), 32'h0);
        chk("rst_ddc3_q", 32'(ddc3_in_q), 32'h0);
        chk("rst_rssi0", rssi_0, 32'h0);
        chk("rst_numchan", 32'(rx_numchan), 32'h0);

        // Widening and two-clock latency; mux=0 sends corr0 everywhere.
        rx_a_a = 12'h100;
        step(1);
        chk("lat_1clk", 32'(ddc0_in_i), 32'h0);
        step(1);
        chk("t1_ddc0_i", 32'(ddc0_in_i), 32'h0800);
        chk("t1_ddc1_i", 32'(ddc1_in_i), 32'h0800);
        chk("t1_ddc2_i", 32'(ddc2_in_i), 32'h0800);
        chk("t1_ddc3_i", 32'(ddc3_in_i), 32'h0800);
        chk("t1_ddc2_q", 32'(ddc2_in_q), 32'h0800);
        chk("t1_numchan", 32'(rx_numchan), 32'h0);

        // Offset preload on ch1, observed by routing corr1 to ddc0 I.
        rx_b_a = 12'h040;
        wr(7'd11, 32'h0000_0100);
        wr(7'd8, 32'h0000_0010);
        step(2);
        chk("t2_corr1", 32'(ddc0_in_i), 32'h0100);
        wr(7'd9, 32'hFFFF_FFFF);
        step(2);
        chk("t2_badaddr_corr", 32'(ddc0_in_i), 32'h0100);
        chk("t2_badaddr_nch", 32'(rx_numchan), 32'h0);

        // Routing: corr0=0800 corr1=0100 corr2=0080 corr3=FF80.
        rx_a_b = 12'h010;
        rx_b_b = 12'hFF0;
        wr(7'd8, 32'h0010_E404);
        step(2);
        chk("t3_numchan", 32'(rx_numchan), 32'h4);
        chk("t3_ddc0_i", 32'(ddc0_in_i), 32'h0800);
        chk("t3_ddc0_q_real", 32'(ddc0_in_q), 32'h0000);
        chk("t3_ddc1_i", 32'(ddc1_in_i), 32'h0800);
        chk("t3_ddc1_q", 32'(ddc1_in_q), 32'h0100);
        chk("t3_ddc2_i", 32'(ddc2_in_i), 32'h0080);
        chk("t3_ddc2_q", 32'(ddc2_in_q), 32'hFF80);
        chk("t3_ddc3_i", 32'(ddc3_in_i), 32'h0800);
        chk("t3_ddc3_q", 32'(ddc3_in_q), 32'h0800);

        // DC loop: start 17 LSB above the preload, loop should walk to 15
        // after roughly 65536/17 + 65536/16 ~= 7951 clocks.
        wr(7'd8, 32'h0);
        wr(7'd10, 32'h0000_3FE7);
        rx_a_a = 12'h7FF;
        step(2);
        chk("t4_corr_start", 32'(ddc0_in_i), 32'h0011);
        enable = 1'b1;
        wr(7'd46, 32'h1);
        done = 1'b0;
        cyc  = 0;
        while (!done && cyc < 12000) begin
            step(1);
            cyc++;
            c = $signed(ddc0_in_i);
            if (c < 16'sd16 && c > -16'sd16) done = 1'b1;
        end
        chk("t4_conv_done", 32'(done), 32'h1);
        chk("t4_conv_value", 32'(ddc0_in_i), 32'h000F);
        chk("t4_conv_time", 32'((cyc > 7800) && (cyc < 8100)), 32'h1);

        // Saturation in both directions with the loop frozen.
        wr(7'd46, 32'h0);
        enable = 1'b0;
        wr(7'd10, 32'h0000_8000);
        step(2);
        chk("t5_sat_pos", 32'(ddc0_in_i), 32'h7FFF);
        rx_a_a = 12'h800;
        wr(7'd10, 32'h0000_7FFF);
        step(2);
        chk("t5_sat_neg", 32'(ddc0_in_i), 32'h8000);

        // Reset mid-operation beats a simultaneous register write.
        rx_a_a = 12'h000;
        serial_strobe = 1'b1; serial_addr = 7'd8; serial_data = 32'hF;
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        serial_strobe = 1'b0; serial_addr = '0; serial_data = '0;
        chk("t6_rst_numchan", 32'(rx_numchan), 32'h0);
        chk("t6_rst_rssi0", rssi_0, 32'h0);
        chk("t6_rst_ddc0_i", 32'(ddc0_in_i), 32'h0);

        // RSSI: 100 overrange samples then 40 zero samples.
        enable = 1'b1;
        rx_a_a = 12'h7FF;
        step(3);
        chk("t6_level_3", 32'(rssi_0[15:0]), 32'd15);
        step(1);
        chk("t6_level_4", 32'(rssi_0[15:0]), 32'd31);
        step(96);
        rx_a_a = 12'h000;
        step(1);
        chk("t6_over_100", 32'(rssi_0[31:16]), 32'd100);
        step(40);
        chk("t6_over_60", 32'(rssi_0[31:16]), 32'd60);
        chk("t6_over_ch1", 32'(rssi_1[31:16]), 32'd0);
        enable = 1'b0;
        rx_a_a = 12'h7FF;
        step(20);
        chk("t6_freeze_over", 32'(rssi_0[31:16]), 32'd60);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
